vip_csc_pipeline: RTL and testbench



---
 rtl/vip_csc_pkg.sv | 41 ++++
 rtl/vip_csc_mac3.sv | 54 +++++
 rtl/vip_csc_pipeline.sv | 158 +++++++++++++++
 tb/tb_vip_csc_pipeline.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vip_csc_pkg.sv
// Shared types and Q8 coefficient tables for the RGB colour-space converter.
package vip_csc_pkg;
    localparam int COEF_FRAC   = 8;
    localparam int COEF_W      = COEF_FRAC + 2;
    localparam int ROUND_CONST = 1 << (COEF_FRAC - 1);

    typedef enum logic [1:0] {
        CSC_601  = 2'd0,
        CSC_709  = 2'd1,
        CSC_GRAY = 2'd2,
        CSC_BIN  = 2'd3
    } csc_mode_e;

    typedef logic signed [COEF_W-1:0] coef_t;

    // Rows are Y, Cb, Cr; columns are R, G, B.
    localparam coef_t COEF_601 [3][3] = '{
        '{ 10'sd77,   10'sd150,  10'sd29 },
        '{-10'sd43,  -10'sd85,   10'sd128},
        '{ 10'sd128, -10'sd107, -10'sd21 }
    };
    localparam coef_t COEF_709 [3][3] = '{
        '{ 10'sd54,   10'sd183,  10'sd19 },
        '{-10'sd29,  -10'sd99,   10'sd128},
        '{ 10'sd128, -10'sd116, -10'sd12 }
    };

    function automatic csc_mode_e decode_mode(input logic [3:0] m);
        case (m)
            4'd1:    return CSC_709;
            4'd2:    return CSC_GRAY;
            4'd3:    return CSC_BIN;
            default: return CSC_601;
        endcase
    endfunction

    // Gray and binary modes derive luma from the BT.601 row.
    function automatic coef_t coef_sel(input csc_mode_e mode, input int ch, input int comp);
        return (mode == CSC_709) ? COEF_709[ch][comp] : COEF_601[ch][comp];
    endfunction
endpackage

// File: rtl/vip_csc_mac3.sv
// One output channel: three signed products (S1), then sum, round, shift and offset (S2).
module vip_csc_mac3
    import vip_csc_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter bit ADD_MID = 1'b0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DATA_W-1:0]                  comp_r,
    input  logic [DATA_W-1:0]                  comp_g,
    input  logic [DATA_W-1:0]                  comp_b,
    input  coef_t                              coef_r,
    input  coef_t                              coef_g,
    input  coef_t                              coef_b,
    output logic signed [DATA_W+COEF_FRAC+2:0] res
);
    localparam int SUM_W = DATA_W + COEF_FRAC + 3;
    typedef logic signed [SUM_W-1:0] sum_t;

    localparam sum_t RND = sum_t'(ROUND_CONST);
    localparam sum_t MID = sum_t'(ADD_MID ? (1 << (DATA_W - 1)) : 0);

    sum_t prod_r_d, prod_g_d, prod_b_d;
    sum_t prod_r_q, prod_g_q, prod_b_q;
    sum_t res_d, res_q;

    function automatic sum_t mul(input logic [DATA_W-1:0] c, input coef_t k);
        return sum_t'($signed({1'b0, c})) * sum_t'(k);
    endfunction

    always_comb begin
        prod_r_d = mul(comp_r, coef_r);
        prod_g_d = mul(comp_g, coef_g);
        prod_b_d = mul(comp_b, coef_b);
        res_d    = ((prod_r_q + prod_g_q + prod_b_q + RND) >>> COEF_FRAC) + MID;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r_q <= '0;
            prod_g_q <= '0;
            prod_b_q <= '0;
            res_q    <= '0;
        end else begin
            prod_r_q <= prod_r_d;
            prod_g_q <= prod_g_d;
            prod_b_q <= prod_b_d;
            res_q    <= res_d;
        end
    end

    assign res = res_q;
endmodule

// File: rtl/vip_csc_pipeline.sv
// RGB to YCbCr / gray / binary converter, 3-cycle latency with matched sync delay.
// Mode and threshold are captured on the rising edge of vsync and held for the frame.
module vip_csc_pipeline #(
    parameter int DATA_W    = 8,
    parameter int COEF_FRAC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [3:0]        per_img_mode,
    input  logic [DATA_W-1:0] per_img_thresh,
    input  logic [DATA_W-1:0] per_img_red,
    input  logic [DATA_W-1:0] per_img_green,
    input  logic [DATA_W-1:0] per_img_blue,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [3:0]        post_img_mode,
    output logic [DATA_W-1:0] post_img_Y,
    output logic [DATA_W-1:0] post_img_Cb,
    output logic [DATA_W-1:0] post_img_Cr,
    output logic              post_img_bit
);
    import vip_csc_pkg::*;

    localparam int SUM_W = DATA_W + COEF_FRAC + 3;
    localparam logic [DATA_W-1:0] MAX_V = '1;
    localparam logic [DATA_W-1:0] MID_V = {1'b1, {(DATA_W-1){1'b0}}};

    logic              vsync_q;
    logic              vs_rise;
    csc_mode_e         active_mode_d, active_mode_q;
    logic [DATA_W-1:0] active_thresh_d, active_thresh_q;

    logic [2:0]        sb1_q, sb2_q, sb3_q;
    csc_mode_e         mode_s1_q, mode_s2_q;
    logic [DATA_W-1:0] thresh_s1_q, thresh_s2_q;

    logic signed [SUM_W-1:0] y_res, cb_res, cr_res;
    logic [DATA_W-1:0]       y_c, cb_c, cr_c;
    csc_mode_e               mode_d, mode_q;
    logic [DATA_W-1:0]       y_d, y_q, cb_d, cb_q, cr_d, cr_q;
    logic                    bit_d, bit_q;

    function automatic logic [DATA_W-1:0] clamp(input logic signed [SUM_W-1:0] v);
        if (v[SUM_W-1])
            return '0;
        else if (|v[SUM_W-2:DATA_W])
            return MAX_V;
        else
            return v[DATA_W-1:0];
    endfunction

    // The edge cycle's own pixel must already see the new settings.
    always_comb begin
        vs_rise         = per_frame_vsync & ~vsync_q;
        active_mode_d   = vs_rise ? decode_mode(per_img_mode) : active_mode_q;
        active_thresh_d = vs_rise ? per_img_thresh : active_thresh_q;
    end

    vip_csc_mac3 #(.DATA_W(DATA_W), .ADD_MID(1'b0)) u_mac_y (
        .clk(clk), .rst_n(rst_n),
        .comp_r(per_img_red), .comp_g(per_img_green), .comp_b(per_img_blue),
        .coef_r(coef_sel(active_mode_d, 0, 0)),
        .coef_g(coef_sel(active_mode_d, 0, 1)),
        .coef_b(coef_sel(active_mode_d, 0, 2)),
        .res(y_res)
    );

    vip_csc_mac3 #(.DATA_W(DATA_W), .ADD_MID(1'b1)) u_mac_cb (
        .clk(clk), .rst_n(rst_n),
        .comp_r(per_img_red), .comp_g(per_img_green), .comp_b(per_img_blue),
        .coef_r(coef_sel(active_mode_d, 1, 0)),
        .coef_g(coef_sel(active_mode_d, 1, 1)),
        .coef_b(coef_sel(active_mode_d, 1, 2)),
        .res(cb_res)
    );

    vip_csc_mac3 #(.DATA_W(DATA_W), .ADD_MID(1'b1)) u_mac_cr (
        .clk(clk), .rst_n(rst_n),
        .comp_r(per_img_red), .comp_g(per_img_green), .comp_b(per_img_blue),
        .coef_r(coef_sel(active_mode_d, 2, 0)),
        .coef_g(coef_sel(active_mode_d, 2, 1)),
        .coef_b(coef_sel(active_mode_d, 2, 2)),
        .res(cr_res)
    );

    always_comb begin
        y_c    = clamp(y_res);
        cb_c   = clamp(cb_res);
        cr_c   = clamp(cr_res);
        mode_d = mode_s2_q;
        y_d    = y_c;
        cb_d   = cb_c;
        cr_d   = cr_c;
        bit_d  = 1'b0;
        case (mode_s2_q)
            CSC_GRAY: begin
                cb_d = MID_V;
                cr_d = MID_V;
            end
            CSC_BIN: begin
                bit_d = (y_c >= thresh_s2_q);
                y_d   = bit_d ? MAX_V : '0;
                cb_d  = MID_V;
                cr_d  = MID_V;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q         <= 1'b0;
            active_mode_q   <= CSC_601;
            active_thresh_q <= '0;
            sb1_q           <= '0;
            sb2_q           <= '0;
            sb3_q           <= '0;
            mode_s1_q       <= CSC_601;
            mode_s2_q       <= CSC_601;
            thresh_s1_q     <= '0;
            thresh_s2_q     <= '0;
            mode_q          <= CSC_601;
            y_q             <= '0;
            cb_q            <= '0;
            cr_q            <= '0;
            bit_q           <= 1'b0;
        end else begin
            vsync_q         <= per_frame_vsync;
            active_mode_q   <= active_mode_d;
            active_thresh_q <= active_thresh_d;
            sb1_q           <= {per_frame_vsync, per_frame_href, per_frame_clken};
            sb2_q           <= sb1_q;
            sb3_q           <= sb2_q;
            mode_s1_q       <= active_mode_d;
            mode_s2_q       <= mode_s1_q;
            thresh_s1_q     <= active_thresh_d;
            thresh_s2_q     <= thresh_s1_q;
            mode_q          <= mode_d;
            y_q             <= y_d;
            cb_q            <= cb_d;
            cr_q            <= cr_d;
            bit_q           <= bit_d;
        end
    end

    assign post_frame_vsync = sb3_q[2];
    assign post_frame_href  = sb3_q[1];
    assign post_frame_clken = sb3_q[0];
    assign post_img_mode    = {2'b00, mode_q};
    assign post_img_Y       = y_q;
    assign post_img_Cb      = cb_q;
    assign post_img_Cr      = cr_q;
    assign post_img_bit     = bit_q;
endmodule

// File: tb/tb_vip_csc_pipeline.sv
// Self-checking bench: constant vector table, hand sequences for mode latch and reset,
// and random traffic against an arithmetic reference model with a 3-deep latency queue.
module tb_vip_csc_pipeline;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       per_frame_vsync, per_frame_href, per_frame_clken;
    logic [3:0] per_img_mode;
    logic [7:0] per_img_thresh, per_img_red, per_img_green, per_img_blue;
    logic       post_frame_vsync, post_frame_href, post_frame_clken;
    logic [3:0] post_img_mode;
    logic [7:0] post_img_Y, post_img_Cb, post_img_Cr;
    logic       post_img_bit;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vip_csc_pipeline #(.DATA_W(8), .COEF_FRAC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
        .per_frame_clken(per_frame_clken), .per_img_mode(per_img_mode),
        .per_img_thresh(per_img_thresh), .per_img_red(per_img_red),
        .per_img_green(per_img_green), .per_img_blue(per_img_blue),
        .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
        .post_frame_clken(post_frame_clken), .post_img_mode(post_img_mode),
        .post_img_Y(post_img_Y), .post_img_Cb(post_img_Cb), .post_img_Cr(post_img_Cr),
        .post_img_bit(post_img_bit)
    );

    typedef struct {
        int vs, hs, ce, mode, y, cb, cr, bt;
        bit chk_c;
    } exp_t;

    typedef struct {
        int r, g, b, mode, th, y, cb, cr, bt, pm;
    } vec_t;

    int   c601 [3][3] = '{'{77, 150, 29}, '{-43, -85, 128}, '{128, -107, -21}};
    int   c709 [3][3] = '{'{54, 183, 19}, '{-29, -99, 128}, '{128, -116, -12}};
    exp_t hist[$];
    int   m_vs_prev, m_mode, m_th;
    vec_t vt[9];

    function automatic int clip(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs just after reset release come from cleared registers; Cb/Cr are not predicted then.
    task automatic model_reset();
        exp_t p;
        p = '{vs: 0, hs: 0, ce: 0, mode: 0, y: 0, cb: 0, cr: 0, bt: 0, chk_c: 1'b0};
        m_vs_prev = 0;
        m_mode = 0;
        m_th = 0;
        hist.delete();
        hist.push_back(p);
        hist.push_back(p);
    endtask

    task automatic model_step();
        exp_t e;
        int   dot[3];
        int   rgb[3];
        rgb = '{int'(per_img_red), int'(per_img_green), int'(per_img_blue)};
        if (per_frame_vsync && m_vs_prev == 0) begin
            m_mode = (per_img_mode <= 4'd3) ? int'(per_img_mode) : 0;
            m_th   = int'(per_img_thresh);
        end
        m_vs_prev = int'(per_frame_vsync);
        for (int ch = 0; ch < 3; ch++) begin
            dot[ch] = 0;
            for (int k = 0; k < 3; k++)
                dot[ch] += ((m_mode == 1) ? c709[ch][k] : c601[ch][k]) * rgb[k];
        end
        e.vs = int'(per_frame_vsync);
        e.hs = int'(per_frame_href);
        e.ce = int'(per_frame_clken);
        e.mode = m_mode;
        e.chk_c = 1'b1;
        e.y  = clip((dot[0] + 128) >>> 8);
        e.cb = clip(((dot[1] + 128) >>> 8) + 128);
        e.cr = clip(((dot[2] + 128) >>> 8) + 128);
        e.bt = 0;
        if (m_mode >= 2) begin
            e.cb = 128;
            e.cr = 128;
        end
        if (m_mode == 3) begin
            e.bt = (e.y >= m_th) ? 1 : 0;
            e.y  = e.bt ? 255 : 0;
        end
        hist.push_back(e);
        if (hist.size() > 3) void'(hist.pop_front());
    endtask

    task automatic check_model();
        exp_t e;
        bit   ok;
        e = hist[0];
        ok = (int'(post_frame_vsync) == e.vs) && (int'(post_frame_href) == e.hs) &&
             (int'(post_frame_clken) == e.ce) && (int'(post_img_mode) == e.mode) &&
             (int'(post_img_Y) == e.y) && (int'(post_img_bit) == e.bt) &&
             (!e.chk_c || (int'(post_img_Cb) == e.cb && int'(post_img_Cr) == e.cr));
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL model t=%0t got vs%0d hs%0d ce%0d m%0d Y%0d Cb%0d Cr%0d b%0d expected vs%0d hs%0d ce%0d m%0d Y%0d Cb%0d Cr%0d b%0d",
                     $time, post_frame_vsync, post_frame_href, post_frame_clken, post_img_mode,
                     post_img_Y, post_img_Cb, post_img_Cr, post_img_bit,
                     e.vs, e.hs, e.ce, e.mode, e.y, e.cb, e.cr, e.bt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        if (rst_n) check_model();
    endtask

    function automatic longint all_outputs();
        return longint'({post_frame_vsync, post_frame_href, post_frame_clken, post_img_mode,
                         post_img_Y, post_img_Cb, post_img_Cr, post_img_bit});
    endfunction

    task automatic set_pix(input int r, input int g, input int b);
        per_img_red   = 8'(r);
        per_img_green = 8'(g);
        per_img_blue  = 8'(b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        vt[0] = '{r: 255, g: 255, b: 255, mode: 0, th: 0,   y: 255, cb: 128, cr: 128, bt: 0, pm: 0};
        vt[1] = '{r: 255, g: 0,   b: 0,   mode: 0, th: 0,   y: 77,  cb: 85,  cr: 255, bt: 0, pm: 0};
        vt[2] = '{r: 255, g: 0,   b: 0,   mode: 1, th: 0,   y: 54,  cb: 99,  cr: 255, bt: 0, pm: 1};
        vt[3] = '{r: 100, g: 100, b: 100, mode: 3, th: 100, y: 255, cb: 128, cr: 128, bt: 1, pm: 3};
        vt[4] = '{r: 99,  g: 99,  b: 99,  mode: 3, th: 100, y: 0,   cb: 128, cr: 128, bt: 0, pm: 3};
        vt[5] = '{r: 255, g: 0,   b: 0,   mode: 9, th: 0,   y: 77,  cb: 85,  cr: 255, bt: 0, pm: 0};
        vt[6] = '{r: 255, g: 0,   b: 0,   mode: 2, th: 0,   y: 77,  cb: 128, cr: 128, bt: 0, pm: 2};
        vt[7] = '{r: 0,   g: 0,   b: 255, mode: 0, th: 0,   y: 29,  cb: 255, cr: 107, bt: 0, pm: 0};
        vt[8] = '{r: 0,   g: 255, b: 0,   mode: 1, th: 0,   y: 182, cb: 29,  cr: 12,  bt: 0, pm: 1};

        rst_n = 1'b0;
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_img_mode    = 4'd0;
        per_img_thresh  = 8'd0;
        set_pix(0, 0, 0);
        #1;
        chk("reset_outputs", all_outputs(), 0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            per_frame_vsync = 1'b0;
            per_frame_href  = 1'b0;
            per_frame_clken = 1'b0;
            tick();
            per_frame_vsync = 1'b1;
            per_frame_href  = 1'b1;
            per_frame_clken = 1'b1;
            per_img_mode    = 4'(vt[i].mode);
            per_img_thresh  = 8'(vt[i].th);
            set_pix(vt[i].r, vt[i].g, vt[i].b);
            tick();
            tick();
            chk("vsync_not_early", longint'(post_frame_vsync), 0);
            tick();
            chk("vsync_at_3", longint'(post_frame_vsync), 1);
            chk("vec_Y", longint'(post_img_Y), vt[i].y);
            chk("vec_Cb", longint'(post_img_Cb), vt[i].cb);
            chk("vec_Cr", longint'(post_img_Cr), vt[i].cr);
            chk("vec_bit", longint'(post_img_bit), vt[i].bt);
            chk("vec_mode", longint'(post_img_mode), vt[i].pm);
        end

        // Mid-frame mode request must be ignored until the next vsync rise.
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        tick();
        per_frame_vsync = 1'b1;
        per_frame_href  = 1'b1;
        per_img_mode    = 4'd0;
        set_pix(255, 0, 0);
        tick();
        per_img_mode = 4'd2;
        repeat (4) tick();
        chk("midframe_mode", longint'(post_img_mode), 0);
        chk("midframe_Cb", longint'(post_img_Cb), 85);
        per_frame_vsync = 1'b0;
        tick();
        per_frame_vsync = 1'b1;
        tick();
        tick();
        chk("relatch_not_early", longint'(post_img_mode), 0);
        tick();
        chk("relatch_mode", longint'(post_img_mode), 2);
        chk("relatch_Cb", longint'(post_img_Cb), 128);
        chk("relatch_Cr", longint'(post_img_Cr), 128);
        chk("relatch_Y", longint'(post_img_Y), 77);

        // Asynchronous reset in the middle of a line.
        repeat (2) tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_outputs(), 0);
        per_frame_vsync = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_reset_mode", longint'(post_img_mode), 0);
        chk("post_reset_Cb", longint'(post_img_Cb), 85);
        chk("post_reset_vsync", longint'(post_frame_vsync), 0);
        repeat (2) tick();
        per_frame_vsync = 1'b1;
        per_img_mode    = 4'd0;
        repeat (3) tick();
        chk("post_reset_frame_Y", longint'(post_img_Y), 77);
        chk("post_reset_frame_vs", longint'(post_frame_vsync), 1);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) per_frame_vsync = ~per_frame_vsync;
            per_frame_href  = 1'($urandom_range(0, 1));
            per_frame_clken = 1'($urandom_range(0, 1));
            per_img_mode    = 4'($urandom_range(0, 15));
            per_img_thresh  = 8'($urandom_range(0, 255));
            set_pix(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
